// File: rtl/qpsk_symbol_demapper.sv
// -----------------------------------------------------------------------------
// qpsk_symbol_demapper
//   Receive-side QPSK hard-decision demapper. Each accepted {Q,I} sample pair
//   is reduced to two bits by sign (negative -> 1), and 16 symbols are packed
//   MSB-first into one 32-bit AXI-Stream word: symbol k lands in bits
//   [31-2k] (from I) and [30-2k] (from Q).
//
//   Optional feature macro: QPSK_RX_LOWMAG_EN
//     When defined, a saturating 16-bit counter (weak_cnt) counts accepted
//     symbols whose |I| or |Q| is below LOWMAG_THRESH. Data path is unchanged.
//
// Ports
//   clk              clock, all state on rising edge
//   reset            asynchronous, active-high reset
//   axis_in_tdata    {Q[31:16], I[15:0]} symbol sample
//   axis_in_tvalid   input sample valid
//   axis_in_tready   input ready (combinational)
//   align            discard partial word, restart symbol count at 0
//   axis_out_tdata   packed data word (registered)
//   axis_out_tvalid  packed word valid (registered)
//   axis_out_tready  downstream ready
//   weak_cnt         saturating weak-symbol count (QPSK_RX_LOWMAG_EN only)
// -----------------------------------------------------------------------------
module qpsk_symbol_demapper #(
  parameter int                  SAMPLE_W      = 16,
  parameter int                  WORD_W        = 32,
  parameter logic [SAMPLE_W-1:0] LOWMAG_THRESH = 16'h2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*SAMPLE_W-1:0] axis_in_tdata,
  input  logic                  axis_in_tvalid,
  output logic                  axis_in_tready,
  input  logic                  align,
  output logic [WORD_W-1:0]     axis_out_tdata,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready
`ifdef QPSK_RX_LOWMAG_EN
  ,
  output logic [15:0]           weak_cnt
`endif
);

  localparam int                SYM_PER_WORD = WORD_W / 2;
  localparam int                CNT_W        = $clog2(SYM_PER_WORD);
  localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST     = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  sym_cnt_r;
  logic [CNT_W-1:0]  sym_cnt_nxt_s;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_nxt_s;
  logic [WORD_W-1:0] out_data_r;
  logic [WORD_W-1:0] out_data_nxt_s;
  logic              out_valid_r;
  logic              out_valid_nxt_s;
  logic              accept_s;
  logic              word_done_s;
  logic [1:0]        sym_bits_s;

  // Sign decision: I sign is the high bit of the pair, Q sign the low bit.
  assign sym_bits_s = {axis_in_tdata[SAMPLE_W-1], axis_in_tdata[2*SAMPLE_W-1]};

  // The last symbol of a word may only enter if the output register can take it.
  assign axis_in_tready = (sym_cnt_r != CNT_LAST) || !out_valid_r || axis_out_tready;
  assign accept_s       = axis_in_tvalid && axis_in_tready;
  // An align in the same cycle restarts the word, so that symbol cannot complete one.
  assign word_done_s    = accept_s && !align && (sym_cnt_r == CNT_LAST);

  assign axis_out_tdata  = out_data_r;
  assign axis_out_tvalid = out_valid_r;

  // Symbol counter and packing shift register next state.
  always_comb begin
    sym_cnt_nxt_s = sym_cnt_r;
    shreg_nxt_s   = shreg_r;
    if (align) begin
      if (accept_s) begin
        sym_cnt_nxt_s = CNT_ONE;
        shreg_nxt_s   = {{(WORD_W-2){1'b0}}, sym_bits_s};
      end else begin
        sym_cnt_nxt_s = CNT_ZERO;
        shreg_nxt_s   = {WORD_W{1'b0}};
      end
    end else if (accept_s) begin
      sym_cnt_nxt_s = sym_cnt_r + CNT_ONE;
      shreg_nxt_s   = {shreg_r[WORD_W-3:0], sym_bits_s};
    end else begin
      sym_cnt_nxt_s = sym_cnt_r;
      shreg_nxt_s   = shreg_r;
    end
  end

  // Output register next state: load on completion, drain on handshake, else hold.
  always_comb begin
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    if (word_done_s) begin
      out_data_nxt_s  = {shreg_r[WORD_W-3:0], sym_bits_s};
      out_valid_nxt_s = 1'b1;
    end else if (out_valid_r && axis_out_tready) begin
      out_data_nxt_s  = out_data_r;
      out_valid_nxt_s = 1'b0;
    end else begin
      out_data_nxt_s  = out_data_r;
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt_r   <= CNT_ZERO;
      shreg_r     <= {WORD_W{1'b0}};
      out_data_r  <= {WORD_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      sym_cnt_r   <= sym_cnt_nxt_s;
      shreg_r     <= shreg_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

`ifdef QPSK_RX_LOWMAG_EN
  // Magnitude of a two's complement sample; the most negative code maps to max positive.
  function automatic logic [SAMPLE_W-1:0] mag_f(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] m;
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      m = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (x[SAMPLE_W-1]) begin
      m = ~x + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

  logic [15:0] weak_cnt_r;
  logic [15:0] weak_cnt_nxt_s;
  logic        weak_sym_s;

  assign weak_sym_s = (mag_f(axis_in_tdata[SAMPLE_W-1:0]) < LOWMAG_THRESH) ||
                      (mag_f(axis_in_tdata[2*SAMPLE_W-1:SAMPLE_W]) < LOWMAG_THRESH);
  assign weak_cnt   = weak_cnt_r;

  // Saturating weak-symbol counter next state.
  always_comb begin
    weak_cnt_nxt_s = weak_cnt_r;
    if (accept_s && weak_sym_s && (weak_cnt_r != 16'hFFFF)) begin
      weak_cnt_nxt_s = weak_cnt_r + 16'd1;
    end else begin
      weak_cnt_nxt_s = weak_cnt_r;
    end
  end

  // Weak-symbol counter register; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weak_cnt_r <= 16'h0000;
    end else begin
      weak_cnt_r <= weak_cnt_nxt_s;
    end
  end
`else
  // Sample magnitudes and the threshold only matter for the weak-symbol counter.
  logic unused_s;
  assign unused_s = ^{axis_in_tdata, LOWMAG_THRESH};
`endif

endmodule

// File: tb/tb_qpsk_symbol_demapper.sv
module tb_qpsk_symbol_demapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] axis_in_tdata;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic        align;
  logic [31:0] axis_out_tdata;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
`ifdef QPSK_RX_LOWMAG_EN
  logic [15:0] weak_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  // reference model state (bit positions within the word, not a shift register)
  int          m_k;
  logic [31:0] m_acc;
  logic [31:0] m_data;
  logic        m_valid;
  int          m_weak;

  always #5 clk = ~clk;

  qpsk_symbol_demapper dut (
    .clk             (clk),
    .reset           (reset),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .align           (align),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready)
`ifdef QPSK_RX_LOWMAG_EN
    ,
    .weak_cnt        (weak_cnt)
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_weak(logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v < 8192;
  endfunction

  // Model + compare, once per cycle on the falling edge.
  initial begin : model_cmp
    bit   rdy;
    bit   acc;
    logic [15:0] si;
    logic [15:0] sq;
    m_k = 0; m_acc = 32'h0; m_data = 32'h0; m_valid = 1'b0; m_weak = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_k = 0; m_acc = 32'h0; m_data = 32'h0; m_valid = 1'b0; m_weak = 0;
      end
      rdy = (m_k != 15) || !m_valid || axis_out_tready;
      chk("out_tvalid", 32'(axis_out_tvalid), 32'(m_valid));
      chk("out_tdata", axis_out_tdata, m_data);
      chk("in_tready", 32'(axis_in_tready), 32'(rdy));
`ifdef QPSK_RX_LOWMAG_EN
      chk("weak_cnt", 32'(weak_cnt), 32'(m_weak));
`endif
      if (!reset) begin
        if (axis_out_tvalid && axis_out_tready) got_q.push_back(axis_out_tdata);
        acc = axis_in_tvalid && rdy;
        si  = axis_in_tdata[15:0];
        sq  = axis_in_tdata[31:16];
        if (m_valid && axis_out_tready) m_valid = 1'b0;
        if (align) begin
          m_k = 0; m_acc = 32'h0;
        end
        if (acc) begin
          if ((is_weak(si) || is_weak(sq)) && m_weak < 65535) m_weak++;
          m_acc[31-2*m_k] = si[15];
          m_acc[30-2*m_k] = sq[15];
          if (m_k == 15) begin
            m_data = m_acc; m_valid = 1'b1; m_k = 0; m_acc = 32'h0;
          end else begin
            m_k++;
          end
        end
      end
    end
  end

  // Random downstream back-pressure while enabled.
  initial begin : rdy_gen
    forever begin
      @(posedge clk); #2;
      if (rand_rdy) axis_out_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [15:0] samp(bit neg);
    logic [15:0] v;
    v = 16'($urandom_range(0, 32767));
    if (neg) v = v | 16'h8000;
    return v;
  endfunction

  function automatic logic [31:0] mk_sym(logic [31:0] w, int k);
    return {samp(w[30-2*k]), samp(w[31-2*k])};
  endfunction

  task automatic send_sym(input logic [31:0] d, input bit al);
    bit acc;
    int waited;
    waited = 0;
    axis_in_tdata = d; axis_in_tvalid = 1'b1; align = al;
    forever begin
      @(negedge clk); acc = axis_in_tready;
      @(posedge clk); #2; align = 1'b0;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: got stalled %0d cycles expected accept at %0t", waited, $time);
        break;
      end
    end
    axis_in_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit first_fixed, input bit al, input bit gaps);
    logic [31:0] d;
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      d = mk_sym(w, k);
      if (first_fixed && k == 0) d = 32'h6665_999B;
      send_sym(d, al && k == 0);
    end
  endtask

  task automatic check_words(string name, input logic [31:0] w0, input logic [31:0] w1, input int n);
    chk({name, "_count"}, 32'(got_q.size()), 32'(n));
    if (got_q.size() > 0) chk({name, "_word0"}, got_q[0], w0);
    if (n > 1 && got_q.size() > 1) chk({name, "_word1"}, got_q[1], w1);
  endtask

  initial begin : main
    logic [31:0] w;
    logic [31:0] d;
    bit          al;
    reset = 1'b1; axis_in_tdata = 32'h0; axis_in_tvalid = 1'b0; align = 1'b0; axis_out_tready = 1'b1;
    repeat (3) tick();
    chk("reset_tvalid", 32'(axis_out_tvalid), 32'h0);
    chk("reset_tdata", axis_out_tdata, 32'h0);
    reset = 1'b0;
    tick();

    // first word, first sample fixed; word registered on the 16th accept edge
    got_q.delete();
    send_word(32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0);
    chk("t1_tvalid", 32'(axis_out_tvalid), 32'h1);
    chk("t1_tdata", axis_out_tdata, 32'hA5A5_0F0F);
    repeat (3) tick();
    check_words("t1", 32'hA5A5_0F0F, 32'h0, 1);

    // zero counts as positive, 0xFFFF negative, 0x0001 positive
    got_q.delete();
    for (int k = 0; k < 16; k++) send_sym((k % 2 == 0) ? 32'h0000_0000 : 32'h0001_FFFF, 1'b0);
    repeat (3) tick();
    check_words("t3", 32'h2222_2222, 32'h0, 1);

    // align discards a 5-symbol partial word
    got_q.delete();
    for (int k = 0; k < 5; k++) send_sym($urandom, 1'b0);
    align = 1'b1; tick(); align = 1'b0;
    send_word(32'h1234_5678, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_words("t4", 32'h1234_5678, 32'h0, 1);

    // back-pressure: 16th symbol of second word stalls until downstream drains
    got_q.delete();
    axis_out_tready = 1'b0;
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) send_sym(mk_sym(32'h0F1E_2D3C, k), 1'b0);
    d = mk_sym(32'h0F1E_2D3C, 15);
    axis_in_tdata = d; axis_in_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t2_stall_ready", 32'(axis_in_tready), 32'h0);
      chk("t2_hold_tdata", axis_out_tdata, 32'hDEAD_BEEF);
    end
    @(posedge clk); #2;
    axis_out_tready = 1'b1;
    send_sym(d, 1'b0);
    chk("t2_reload_tdata", axis_out_tdata, 32'h0F1E_2D3C);
    repeat (3) tick();
    check_words("t2", 32'hDEAD_BEEF, 32'h0F1E_2D3C, 2);

    // reset with a pending word and a half-built word
    got_q.delete();
    axis_out_tready = 1'b0;
    send_word(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_sym($urandom, 1'b0);
    reset = 1'b1;
    tick();
    chk("t5_rst_tvalid", 32'(axis_out_tvalid), 32'h0);
    chk("t5_rst_tdata", axis_out_tdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_post_tvalid", 32'(axis_out_tvalid), 32'h0);
`ifdef QPSK_RX_LOWMAG_EN
    for (int k = 0; k < 3; k++) send_sym(32'h4000_0100, 1'b0);
    chk("t6_weak_cnt", 32'(weak_cnt), 32'h3);
    align = 1'b1; tick(); align = 1'b0;
`endif
    axis_out_tready = 1'b1;
    got_q.delete();
    send_word(32'h3C3C_C3C3, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_words("t5", 32'h3C3C_C3C3, 32'h0, 1);

    // randomized words with gaps, back-pressure, partial words and align
    got_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      al = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 10)); k++) send_sym($urandom, 1'b0);
        al = 1'b1;
      end
      w = $urandom;
      send_word(w, 1'b0, al, 1'b1);
      exp_q.push_back(w);
    end
    rand_rdy = 1'b0;
    tick();
    axis_out_tready = 1'b1;
    repeat (5) tick();
    chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("rand_word", got_q[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
